// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game-flow controller and its environment:
// frame/start/crash inputs in, state, enables and HUD counters out.
interface game_flow_ctrl_if #(
  parameter int SCORE_W = 14
);
  logic               frame_tick;
  logic               start;
  logic               crash;
  logic [1:0]         state;
  logic               run_en;
  logic               init_pulse;
  logic               plane_visible;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               new_record;

  modport master (
    output frame_tick, start, crash,
    input  state, run_en, init_pulse, plane_visible, score, high_score, new_record
  );

  modport slave (
    input  frame_tick, start, crash,
    output state, run_en, init_pulse, plane_visible, score, high_score, new_record
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer IDLE -> PLAY -> DYING -> OVER driven by the frame tick and crash flag;
// owns the generator enables, the plane blink, and the score/high-score counters.
module game_flow_ctrl #(
  parameter int SCORE_W      = 14,
  parameter int SCORE_DIV    = 30,
  parameter int GRACE_FRAMES = 8,
  parameter int DYING_FRAMES = 90,
  parameter int FLASH_FRAMES = 6
) (
  input  logic             clk,
  input  logic             reset,
  game_flow_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam int DIV_W   = (SCORE_DIV > 1)    ? $clog2(SCORE_DIV)        : 1;
  localparam int DYING_W = (DYING_FRAMES > 1) ? $clog2(DYING_FRAMES)     : 1;
  localparam int FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES)     : 1;

  localparam logic [GRACE_W-1:0] GRACE_LAST = GRACE_W'(GRACE_FRAMES);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCORE_DIV - 1);
  localparam logic [DYING_W-1:0] DYING_LAST = DYING_W'(DYING_FRAMES - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  state_t             state_reg, state_next;
  logic               start_q_reg;
  logic               armed_reg;
  logic [GRACE_W-1:0] grace_reg, grace_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [DYING_W-1:0] dying_reg, dying_next;
  logic [FLASH_W-1:0] flash_reg, flash_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [SCORE_W-1:0] high_reg, high_next;
  logic               new_record_reg, new_record_next;
  logic               init_reg, init_next;
  logic               visible_reg, visible_next;
  logic               run_en_reg, run_en_next;
  logic               start_rise;

  // A start held high through reset release must be seen low once before it can launch a game.
  assign start_rise = bus.start & ~start_q_reg & armed_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      start_q_reg    <= 1'b0;
      armed_reg      <= 1'b0;
      grace_reg      <= '0;
      div_reg        <= '0;
      dying_reg      <= '0;
      flash_reg      <= '0;
      score_reg      <= '0;
      high_reg       <= '0;
      new_record_reg <= 1'b0;
      init_reg       <= 1'b0;
      visible_reg    <= 1'b1;
      run_en_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      start_q_reg    <= bus.start;
      armed_reg      <= armed_reg | ~bus.start;
      grace_reg      <= grace_next;
      div_reg        <= div_next;
      dying_reg      <= dying_next;
      flash_reg      <= flash_next;
      score_reg      <= score_next;
      high_reg       <= high_next;
      new_record_reg <= new_record_next;
      init_reg       <= init_next;
      visible_reg    <= visible_next;
      run_en_reg     <= run_en_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grace_next      = grace_reg;
    div_next        = div_reg;
    dying_next      = dying_reg;
    flash_next      = flash_reg;
    score_next      = score_reg;
    high_next       = high_reg;
    new_record_next = new_record_reg;
    init_next       = 1'b0;
    visible_next    = visible_reg;

    unique case (state_reg)
      IDLE, OVER: begin
        if (start_rise) begin
          state_next      = PLAY;
          score_next      = '0;
          new_record_next = 1'b0;
          grace_next      = '0;
          div_next        = '0;
          dying_next      = '0;
          flash_next      = '0;
          init_next       = 1'b1;
          visible_next    = 1'b1;
        end
      end

      PLAY: begin
        if (bus.frame_tick) begin
          if (grace_reg < GRACE_LAST) begin
            grace_next = grace_reg + 1'b1;
          end
          if (bus.crash && (grace_reg >= GRACE_LAST)) begin
            state_next   = DYING;
            visible_next = 1'b0;
            dying_next   = '0;
            flash_next   = '0;
          end else if (div_reg == DIV_LAST) begin
            div_next = '0;
            if (score_reg != SCORE_MAX) begin
              score_next = score_reg + 1'b1;
            end
          end else begin
            div_next = div_reg + 1'b1;
          end
        end
      end

      DYING: begin
        if (bus.frame_tick) begin
          if (dying_reg == DYING_LAST) begin
            state_next   = OVER;
            visible_next = 1'b1;
            if (score_reg > high_reg) begin
              high_next       = score_reg;
              new_record_next = 1'b1;
            end
          end else begin
            dying_next = dying_reg + 1'b1;
            if (flash_reg == FLASH_LAST) begin
              flash_next   = '0;
              visible_next = ~visible_reg;
            end else begin
              flash_next = flash_reg + 1'b1;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase

    run_en_next = (state_next == PLAY);
  end

  assign bus.state         = state_reg;
  assign bus.run_en        = run_en_reg;
  assign bus.init_pulse    = init_reg;
  assign bus.plane_visible = visible_reg;
  assign bus.score         = score_reg;
  assign bus.high_score    = high_reg;
  assign bus.new_record    = new_record_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: default-parameter instance for the full game flow,
// plus a tiny 2-bit-score instance to reach score saturation quickly.
module tb_game_flow_ctrl;

  localparam int DYING_N = 90;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  game_flow_ctrl_if #(.SCORE_W(14)) bus0 ();
  game_flow_ctrl_if #(.SCORE_W(2))  bus1 ();

  game_flow_ctrl #(
    .SCORE_W(14), .SCORE_DIV(30), .GRACE_FRAMES(8), .DYING_FRAMES(DYING_N), .FLASH_FRAMES(6)
  ) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  game_flow_ctrl #(
    .SCORE_W(2), .SCORE_DIV(1), .GRACE_FRAMES(0), .DYING_FRAMES(1), .FLASH_FRAMES(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic tick0();
    @(negedge clk) bus0.frame_tick = 1'b1;
    @(negedge clk) bus0.frame_tick = 1'b0;
  endtask

  task automatic tick1();
    @(negedge clk) bus1.frame_tick = 1'b1;
    @(negedge clk) bus1.frame_tick = 1'b0;
  endtask

  // One full game on the default instance: score for n ticks, crash, run out DYING.
  task automatic play_game(input string tag, input int n, input int exp_score,
                           input int exp_hs, input int exp_nr);
    bus0.crash = 1'b0;
    bus0.start = 1'b0;
    cyc();
    bus0.start = 1'b1;
    cyc();
    chk({tag, ".entry_state"}, 32'(bus0.state), 32'd1);
    chk({tag, ".entry_init"},  32'(bus0.init_pulse), 32'd1);
    chk({tag, ".entry_score"}, 32'(bus0.score), 32'd0);
    chk({tag, ".entry_nrec"},  32'(bus0.new_record), 32'd0);
    cyc();
    chk({tag, ".init_gone"}, 32'(bus0.init_pulse), 32'd0);
    for (int i = 1; i <= n; i++) begin
      tick0();
      if (i == 95) chk({tag, ".score_at95"}, 32'(bus0.score), 32'd3);
    end
    chk({tag, ".score"}, 32'(bus0.score), 32'(exp_score));
    bus0.crash = 1'b1;
    tick0();
    bus0.crash = 1'b0;
    chk({tag, ".dying"}, 32'(bus0.state), 32'd2);
    chk({tag, ".crash_no_inc"}, 32'(bus0.score), 32'(exp_score));
    repeat (DYING_N) tick0();
    chk({tag, ".over"}, 32'(bus0.state), 32'd3);
    chk({tag, ".high"}, 32'(bus0.high_score), 32'(exp_hs));
    chk({tag, ".nrec"}, 32'(bus0.new_record), 32'(exp_nr));
    chk({tag, ".held"}, 32'(bus0.score), 32'(exp_score));
  endtask

  initial begin
    reset = 1'b1;
    bus0.frame_tick = 1'b0; bus0.start = 1'b0; bus0.crash = 1'b0;
    bus1.frame_tick = 1'b0; bus1.start = 1'b0; bus1.crash = 1'b0;
    repeat (3) cyc();
    chk("rst.state",   32'(bus0.state), 32'd0);
    chk("rst.run_en",  32'(bus0.run_en), 32'd0);
    chk("rst.init",    32'(bus0.init_pulse), 32'd0);
    chk("rst.visible", 32'(bus0.plane_visible), 32'd1);
    chk("rst.score",   32'(bus0.score), 32'd0);
    chk("rst.high",    32'(bus0.high_score), 32'd0);
    reset = 1'b0;
    cyc();

    // game 1: start rise, crash held from entry through the grace window
    bus0.start = 1'b1;
    cyc();
    chk("g1.state",  32'(bus0.state), 32'd1);
    chk("g1.init",   32'(bus0.init_pulse), 32'd1);
    chk("g1.run_en", 32'(bus0.run_en), 32'd1);
    chk("g1.score",  32'(bus0.score), 32'd0);
    bus0.crash = 1'b1;
    cyc();
    chk("g1.init_gone", 32'(bus0.init_pulse), 32'd0);
    chk("g1.hold_start", 32'(bus0.state), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick0();
      chk($sformatf("grace.tick%0d", i), 32'(bus0.state), 32'd1);
    end
    tick0();
    chk("grace.dying",   32'(bus0.state), 32'd2);
    chk("grace.run_en",  32'(bus0.run_en), 32'd0);
    chk("grace.visible", 32'(bus0.plane_visible), 32'd0);
    chk("grace.score",   32'(bus0.score), 32'd0);
    bus0.crash = 1'b0;

    // a fresh start edge in DYING must be ignored
    bus0.start = 1'b0;
    cyc();
    bus0.start = 1'b1;
    cyc();
    chk("dying.start_ignored", 32'(bus0.state), 32'd2);

    for (int i = 1; i < DYING_N; i++) begin
      tick0();
      if ((i % 6) == 0 || (i % 6) == 5)
        chk($sformatf("flash.tick%0d", i), 32'(bus0.plane_visible), 32'((i / 6) % 2));
    end
    chk("dying.last", 32'(bus0.state), 32'd2);
    tick0();
    chk("g1.over",    32'(bus0.state), 32'd3);
    chk("g1.visible", 32'(bus0.plane_visible), 32'd1);
    chk("g1.run_en",  32'(bus0.run_en), 32'd0);
    chk("g1.high",    32'(bus0.high_score), 32'd0);
    chk("g1.nrec",    32'(bus0.new_record), 32'd0);

    play_game("g2", 150, 5, 5, 1);
    play_game("g3", 150, 5, 5, 0);
    play_game("g4", 210, 7, 7, 1);

    // saturation on the 2-bit instance: a point per tick, no grace, one dying frame
    bus1.start = 1'b1;
    cyc();
    chk("sat.state", 32'(bus1.state), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick1();
      chk($sformatf("sat.tick%0d", i), 32'(bus1.score), 32'((i > 3) ? 3 : i));
    end
    bus1.crash = 1'b1;
    tick1();
    chk("sat.dying",  32'(bus1.state), 32'd2);
    chk("sat.score",  32'(bus1.score), 32'd3);
    tick1();
    chk("sat.over",   32'(bus1.state), 32'd3);
    chk("sat.high",   32'(bus1.high_score), 32'd3);
    chk("sat.nrec",   32'(bus1.new_record), 32'd1);

    // asynchronous reset in the middle of DYING, with start held across release
    bus0.start = 1'b0;
    cyc();
    bus0.start = 1'b1;
    bus0.crash = 1'b1;
    cyc();
    repeat (9) tick0();
    chk("ar.dying", 32'(bus0.state), 32'd2);
    repeat (10) tick0();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar.state",   32'(bus0.state), 32'd0);
    chk("ar.high",    32'(bus0.high_score), 32'd0);
    chk("ar.visible", 32'(bus0.plane_visible), 32'd1);
    chk("ar.run_en",  32'(bus0.run_en), 32'd0);
    bus0.crash = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (5) cyc();
    chk("ar.held_start", 32'(bus0.state), 32'd0);
    bus0.start = 1'b0;
    cyc();
    bus0.start = 1'b1;
    cyc();
    chk("ar.restart", 32'(bus0.state), 32'd1);
    chk("ar.init",    32'(bus0.init_pulse), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
